// File: rtl/button_pkg.sv
// button_pkg: clk_mode encoding and small constant helpers shared by the
// button_event_unit files.
package button_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_NORMAL   = 2'd0;
  localparam mode_t MODE_SET_TIME = 2'd1;
  localparam mode_t MODE_ALARM    = 2'd2;
  localparam mode_t MODE_SET_DATE = 2'd3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold the values 0..max_val (never less than one bit).
  function automatic int width_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_event_unit_if.sv
// button_event_unit_if: pin-side and event-side signals of button_event_unit.
// master = board/consumer side, slave = the button unit itself.
interface button_event_unit_if
  import button_pkg::*;
#(
  parameter int N_BTN = 7
);
  logic [N_BTN-1:0] pButton;
  logic [N_BTN-1:0] sButton;
  logic [N_BTN-1:0] vPress;
  logic [N_BTN-1:0] vRelease;
  logic [N_BTN-1:0] vHold;
  mode_t            clk_mode;

  modport master (output pButton, input sButton, vPress, vRelease, vHold, clk_mode);
  modport slave  (input pButton, output sButton, vPress, vRelease, vHold, clk_mode);
endinterface

// File: rtl/button_channel.sv
// button_channel: one push-button pin. Two-flop synchroniser, tick-sampled
// agreement debounce, hold counter and registered press/release/hold pulses.
// With BTN_AUTOREPEAT_EN defined, non-mode channels also re-fire vPress at the
// hold point and then every REPEAT_TICKS ticks while the button stays down.
module button_channel
  import button_pkg::*;
#(
  parameter int STABLE_SAMPLES = 3,
  parameter int HOLD_TICKS     = 200,
  parameter int REPEAT_TICKS   = 40
`ifdef BTN_AUTOREPEAT_EN
  , parameter bit IS_MODE      = 1'b0
`endif
) (
  input  logic mclk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_pin,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_hold
);
  localparam int HOLD_MAX = max_int(HOLD_TICKS, REPEAT_TICKS) + 1;
  localparam int HW       = width_for(HOLD_MAX);
  localparam logic [HW-1:0] L_HOLD_MAX  = HW'(HOLD_MAX);
  localparam logic [HW-1:0] L_HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [3:0]    L_STABLE    = 4'(STABLE_SAMPLES);

  logic          r_sync1, r_sync2, r_level;
  logic          r_press, r_release, r_hold;
  logic [3:0]    r_agree;
  logic [HW-1:0] r_hold_cnt;
  logic [3:0]    w_agree_inc;
  logic          w_flip, w_hold_hit, w_press_evt;

  // Debounce decision and hold-threshold detection for the current cycle.
  always_comb begin
    w_agree_inc = (r_agree == 4'hF) ? 4'hF : r_agree + 4'd1;
    w_flip      = i_tick && (r_sync2 != r_level) && (w_agree_inc == L_STABLE);
    w_hold_hit  = i_tick && r_level && (r_hold_cnt == L_HOLD_LAST);
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = width_for(REPEAT_TICKS);
  localparam logic [RW-1:0] L_REP_LAST   = RW'(REPEAT_TICKS - 1);
  localparam logic [HW-1:0] L_HOLD_TICKS = HW'(HOLD_TICKS);

  logic [RW-1:0] r_rep_cnt;
  logic          w_past_hold, w_rep_hit;

  // Press sources: debounced rise, plus hold point and repeat period off mode keys.
  always_comb begin
    w_past_hold = r_level && (r_hold_cnt >= L_HOLD_TICKS);
    w_rep_hit   = i_tick && w_past_hold && (r_rep_cnt == L_REP_LAST);
    w_press_evt = (w_flip && !r_level) || (!IS_MODE && (w_hold_hit || w_rep_hit));
  end

  // Repeat phase counter: restarts at each hold point and each repeat pulse.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_rep_cnt <= '0;
    end else if (!r_level || w_hold_hit || w_rep_hit) begin
      r_rep_cnt <= '0;
    end else if (i_tick && w_past_hold) begin
      r_rep_cnt <= r_rep_cnt + RW'(1);
    end else begin
      r_rep_cnt <= r_rep_cnt;
    end
  end
`else
  // Without auto-repeat, a press is only ever a debounced rise.
  always_comb w_press_evt = w_flip && !r_level;
`endif

  // Synchroniser, agreement counter, debounced level, hold counter and pulses.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_level    <= 1'b0;
      r_agree    <= 4'd0;
      r_hold_cnt <= '0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_hold     <= 1'b0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      if (i_tick) begin
        r_agree <= ((r_sync2 == r_level) || w_flip) ? 4'd0 : w_agree_inc;
      end
      if (w_flip) begin
        r_level <= !r_level;
      end
      if (!r_level) begin
        r_hold_cnt <= '0;
      end else if (i_tick && (r_hold_cnt != L_HOLD_MAX)) begin
        r_hold_cnt <= r_hold_cnt + HW'(1);
      end
      r_press   <= w_press_evt;
      r_release <= w_flip && r_level;
      r_hold    <= w_hold_hit;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_hold    = r_hold;
endmodule

// File: rtl/button_event_unit.sv
// button_event_unit: N_BTN debounced push-button front end with press,
// release, long-press (and, with BTN_AUTOREPEAT_EN, auto-repeat) pulses and
// the clock-mode state machine driven by the Set and Alarm channels.
module button_event_unit
  import button_pkg::*;
#(
  parameter int N_BTN          = 7,
  parameter int MFREQ_KHZ      = 1,
  parameter int DEBOUNCE_MS    = 5,
  parameter int STABLE_SAMPLES = 3,
  parameter int HOLD_MS        = 1000,
  parameter int REPEAT_MS      = 200,
  parameter int SET_IDX        = 2,
  parameter int ALARM_IDX      = 1
) (
  input  logic                mclk,
  input  logic                rst,
  button_event_unit_if.slave  bus
);
  localparam int TICK         = MFREQ_KHZ * DEBOUNCE_MS;
  localparam int HOLD_TICKS   = HOLD_MS / DEBOUNCE_MS;
  localparam int REPEAT_TICKS = REPEAT_MS / DEBOUNCE_MS;
  localparam int TW           = width_for(TICK - 1);
  localparam logic [TW-1:0] L_TICK_LAST = TW'(TICK - 1);

  logic [TW-1:0]    r_tick_cnt;
  logic             w_tick;
  logic [N_BTN-1:0] w_level, w_press, w_release, w_hold;
  mode_t            r_mode;

  assign w_tick = (r_tick_cnt == L_TICK_LAST);

  // Shared sample-period counter, wrapping after TICK cycles.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    button_channel #(
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .HOLD_TICKS     (HOLD_TICKS),
      .REPEAT_TICKS   (REPEAT_TICKS)
`ifdef BTN_AUTOREPEAT_EN
      , .IS_MODE      ((g == SET_IDX) || (g == ALARM_IDX))
`endif
    ) u_ch (
      .mclk      (mclk),
      .rst       (rst),
      .i_tick    (w_tick),
      .i_pin     (bus.pButton[g]),
      .o_level   (w_level[g]),
      .o_press   (w_press[g]),
      .o_release (w_release[g]),
      .o_hold    (w_hold[g])
    );
  end

  // Mode FSM. Mode channels never auto-repeat, so their vPress is always a
  // debounced rise; Set takes priority when both rise together.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_mode <= MODE_NORMAL;
    end else if (w_press[SET_IDX]) begin
      case (r_mode)
        MODE_NORMAL:   r_mode <= MODE_SET_TIME;
        MODE_SET_TIME: r_mode <= MODE_SET_DATE;
        MODE_SET_DATE: r_mode <= MODE_NORMAL;
        MODE_ALARM:    r_mode <= MODE_ALARM;
        default:       r_mode <= MODE_NORMAL;
      endcase
    end else if (w_press[ALARM_IDX]) begin
      case (r_mode)
        MODE_NORMAL:   r_mode <= MODE_ALARM;
        MODE_ALARM:    r_mode <= MODE_NORMAL;
        MODE_SET_TIME: r_mode <= MODE_SET_TIME;
        MODE_SET_DATE: r_mode <= MODE_SET_DATE;
        default:       r_mode <= MODE_NORMAL;
      endcase
    end else begin
      r_mode <= r_mode;
    end
  end

  assign bus.sButton  = w_level;
  assign bus.vPress   = w_press;
  assign bus.vRelease = w_release;
  assign bus.vHold    = w_hold;
  assign bus.clk_mode = r_mode;
endmodule

// File: tb/tb_button_event_unit.sv
// Testbench for button_event_unit (TICK=2, STABLE=3, HOLD=10, REPEAT=4 ticks).
// Works with or without BTN_AUTOREPEAT_EN.
module tb_button_event_unit;
  import button_pkg::*;

  localparam int N      = 7;
  localparam int TICK   = 2;
  localparam int STABLE = 3;
  localparam int HOLD   = 10;
  localparam int REPEAT = 4;
  localparam int SET    = 2;
  localparam int ALM    = 1;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic mclk = 1'b0;
  logic rst  = 1'b1;
  always #5 mclk = ~mclk;

  button_event_unit_if #(.N_BTN(N)) bus ();

  button_event_unit #(
    .N_BTN(N), .MFREQ_KHZ(2), .DEBOUNCE_MS(1), .STABLE_SAMPLES(STABLE),
    .HOLD_MS(10), .REPEAT_MS(4), .SET_IDX(SET), .ALARM_IDX(ALM)
  ) dut (
    .mclk (mclk),
    .rst  (rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pin history, per-channel run of disagreeing samples and
  // ticks spent pressed; presses/holds derived arithmetically from that.
  logic [N-1:0] m_d1, m_d2, m_lvl, m_prs, m_rel, m_hld;
  mode_t        m_mode;
  int           m_ncyc;
  int           m_run  [N];
  int           m_held [N];
  mode_t set_next   [4] = '{MODE_SET_TIME, MODE_SET_DATE, MODE_ALARM, MODE_NORMAL};
  mode_t alarm_next [4] = '{MODE_ALARM, MODE_SET_TIME, MODE_NORMAL, MODE_SET_DATE};

  logic [4*N+1:0] dut_vec, mdl_vec;
  assign dut_vec = {bus.sButton, bus.vPress, bus.vRelease, bus.vHold, bus.clk_mode};
  assign mdl_vec = {m_lvl, m_prs, m_rel, m_hld, m_mode};

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0; m_hld = '0;
    m_mode = MODE_NORMAL; m_ncyc = 0;
    for (int c = 0; c < N; c++) begin
      m_run[c] = 0; m_held[c] = 0;
    end
  endtask

  task automatic model_step();
    logic         tick;
    logic [N-1:0] samp, lvl_old;
    tick = ((m_ncyc % TICK) == TICK - 1);
    m_ncyc++;
    if (m_prs[SET])      m_mode = set_next[m_mode];
    else if (m_prs[ALM]) m_mode = alarm_next[m_mode];
    samp = m_d2; m_d2 = m_d1; m_d1 = bus.pButton;
    lvl_old = m_lvl;
    m_prs = '0; m_rel = '0; m_hld = '0;
    for (int c = 0; c < N; c++) begin
      if (!lvl_old[c]) m_held[c] = 0;
      else if (tick) begin
        m_held[c]++;
        if (m_held[c] == HOLD) m_hld[c] = 1'b1;
        if (AR && c != SET && c != ALM && m_held[c] >= HOLD && ((m_held[c] - HOLD) % REPEAT) == 0)
          m_prs[c] = 1'b1;
      end
      if (tick) begin
        if (samp[c] == lvl_old[c]) m_run[c] = 0;
        else begin
          m_run[c]++;
          if (m_run[c] == STABLE) begin
            m_run[c] = 0;
            m_lvl[c] = ~lvl_old[c];
            if (lvl_old[c]) m_rel[c] = 1'b1;
            else            m_prs[c] = 1'b1;
          end
        end
      end
    end
  endtask

  // One clock: model follows the DUT edge, outputs are then sampled at negedge.
  task automatic step();
    @(posedge mclk);
    if (!rst) model_step();
    @(negedge mclk);
  endtask

  task automatic press_btn(input logic [N-1:0] mask);
    bus.pButton = mask;
    repeat (12) step();
    bus.pButton = '0;
    repeat (16) step();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge mclk);
    n_checks++;
    if (dut_vec !== '0) begin
      n_fail++; $display("FAIL reset_state got=%h want=0", dut_vec);
    end
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (dut_vec !== mdl_vec) begin
        n_fail++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
      end
    end
  endtask

  task automatic test_clean_press();
    int early = 0;
    int rel   = 0;
    bus.pButton = N'(1);
    for (int i = 0; i < 40; i++) begin
      step();
      if (i < 9 && bus.vPress[0]) early++;
      n_checks++;
      if (dut_vec !== mdl_vec) begin
        n_fail++; $display("FAIL clean_press cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
      end
      if (i == 8) begin
        n_checks++;
        if (bus.sButton[0] !== 1'b1) begin
          n_fail++; $display("FAIL clean_press_level got=%b want=1", bus.sButton[0]);
        end
      end
    end
    n_checks++;
    if (early != 1) begin
      n_fail++; $display("FAIL clean_press_latency presses=%0d want=1", early);
    end
    bus.pButton = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.vRelease[0]) rel++;
      n_checks++;
      if (dut_vec !== mdl_vec) begin
        n_fail++; $display("FAIL clean_release cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
      end
    end
    n_checks++;
    if (rel != 1) begin
      n_fail++; $display("FAIL clean_release_count got=%0d want=1", rel);
    end
  endtask

  task automatic test_glitch();
    int evts = 0;
    int lvl_seen = 0;
    for (int i = 0; i < 50; i++) begin
      bus.pButton = (i < 40 && ((i / 4) % 2) == 0) ? N'(8) : '0;
      step();
      if (bus.vPress[3] || bus.vRelease[3] || bus.vHold[3]) evts++;
      if (bus.sButton[3]) lvl_seen++;
      n_checks++;
      if (dut_vec !== mdl_vec) begin
        n_fail++; $display("FAIL glitch cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
      end
    end
    n_checks++;
    if (evts != 0 || lvl_seen != 0) begin
      n_fail++; $display("FAIL glitch_reject events=%0d level_cycles=%0d want=0,0", evts, lvl_seen);
    end
  endtask

  task automatic test_hold_repeat();
    int presses = 0;
    int holds   = 0;
    for (int i = 0; i < 76; i++) begin
      bus.pButton = (i < 56) ? N'(1) : '0;
      step();
      if (bus.vPress[0]) presses++;
      if (bus.vHold[0])  holds++;
      n_checks++;
      if (dut_vec !== mdl_vec) begin
        n_fail++; $display("FAIL hold_repeat cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
      end
    end
    n_checks++;
    if (presses != (AR ? 6 : 1) || holds != 1) begin
      n_fail++; $display("FAIL hold_repeat_count press=%0d hold=%0d want=%0d,1", presses, holds, AR ? 6 : 1);
    end
  endtask

  task automatic test_mode_cycle();
    mode_t exp_seq [5] = '{MODE_SET_TIME, MODE_SET_DATE, MODE_NORMAL, MODE_ALARM, MODE_NORMAL};
    for (int k = 0; k < 5; k++) begin
      press_btn((k < 3) ? N'(1 << SET) : N'(1 << ALM));
      n_checks++;
      if (bus.clk_mode !== exp_seq[k]) begin
        n_fail++; $display("FAIL mode_cycle step=%0d got=%0d want=%0d", k, bus.clk_mode, exp_seq[k]);
      end
    end
  endtask

  task automatic test_mode_ignore();
    logic [N-1:0] seq [7];
    mode_t        exp_seq [7] = '{MODE_SET_TIME, MODE_SET_TIME, MODE_SET_DATE, MODE_NORMAL,
                                  MODE_SET_TIME, MODE_SET_DATE, MODE_NORMAL};
    seq = '{N'(1 << SET), N'(1 << ALM), N'(1 << SET), N'(1 << SET),
            N'((1 << SET) | (1 << ALM)), N'(1 << SET), N'(1 << SET)};
    for (int k = 0; k < 7; k++) begin
      press_btn(seq[k]);
      n_checks++;
      if (bus.clk_mode !== exp_seq[k]) begin
        n_fail++; $display("FAIL mode_ignore step=%0d got=%0d want=%0d", k, bus.clk_mode, exp_seq[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] p;
    for (int i = 0; i < 820; i++) begin
      p = bus.pButton;
      if (i < 800) begin
        for (int b = 0; b < N; b++)
          if ($urandom_range(0, 11) == 0) p[b] = ~p[b];
      end else begin
        p = '0;
      end
      bus.pButton = p;
      step();
      n_checks++;
      if (dut_vec !== mdl_vec) begin
        n_fail++; $display("FAIL random cyc=%0d pins=%b got=%h want=%h", i, p, dut_vec, mdl_vec);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    int    found   = -1;
    mode_t mode_at = MODE_SET_DATE;
    bus.pButton = N'(2);
    for (int i = 0; i < 30; i++) begin
      step();
      n_checks++;
      if (dut_vec !== mdl_vec) begin
        n_fail++; $display("FAIL pre_reset cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
      end
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dut_vec !== '0) begin
        n_fail++; $display("FAIL reset_mid_hold cyc=%0d got=%h want=0", i, dut_vec);
      end
      if (i < 3) @(negedge mclk);
    end
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (found < 0 && bus.vPress[1]) begin
        found = i; mode_at = bus.clk_mode;
      end
      n_checks++;
      if (dut_vec !== mdl_vec) begin
        n_fail++; $display("FAIL post_reset cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
      end
    end
    n_checks++;
    if (found < 0 || found >= 2 + TICK * (STABLE + 1)) begin
      n_fail++; $display("FAIL post_reset_press cycle=%0d want 0..%0d", found, 1 + TICK * (STABLE + 1));
    end
    n_checks++;
    if (mode_at !== MODE_NORMAL) begin
      n_fail++; $display("FAIL post_reset_mode got=%0d want=0", mode_at);
    end
  endtask

  initial begin
    bus.pButton = '0;
    model_reset();
    test_reset();
    test_clean_press();
    test_glitch();
    test_hold_repeat();
    test_mode_cycle();
    test_mode_ignore();
    test_random();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
